// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM states; only these four are reachable.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr   = 2'd1,
    StRd   = 2'd2,
    StResp = 2'd3
  } state_e;

  // Default number of RD cycles allowed before the read is aborted.
  localparam int unsigned TimeoutDefault = 15;

  // Memory write mask driven whenever no write is in flight.
  localparam logic [3:0] MaskIdle = 4'b1111;

  // Counter width able to hold 0..t.
  function automatic int unsigned cnt_width(int unsigned t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the shared memory port.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned W  = 32
) ();

  // Requester port 0
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [W-1:0]  wdata0;
  logic [3:0]    wmask0;
  logic          ack0;
  logic [W-1:0]  rdata0;
  logic          err0;

  // Requester port 1
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [W-1:0]  wdata1;
  logic [3:0]    wmask1;
  logic          ack1;
  logic [W-1:0]  rdata1;
  logic          err1;

  // Memory port
  logic          ren;
  logic          wen;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic [3:0]    wmask;
  logic [W-1:0]  rdata;
  logic          rd_valid;

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0, wmask0,
    output ack0, rdata0, err0,
    input  req1, we1, addr1, wdata1, wmask1,
    output ack1, rdata1, err1,
    output ren, wen, addr, wdata, wmask,
    input  rdata, rd_valid
  );

  // Requesters plus memory model side.
  modport master (
    output req0, we0, addr0, wdata0, wmask0,
    input  ack0, rdata0, err0,
    output req1, we1, addr1, wdata1, wmask1,
    input  ack1, rdata1, err1,
    input  ren, wen, addr, wdata, wmask,
    output rdata, rd_valid
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker. last_q remembers the port granted
// most recently; it resets to port 1 so that port 0 wins the first tie.
module mem_arbiter_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic en_i,
  output logic gnt_valid_o,
  output logic gnt_o
);

  logic last_q, last_d;

  // Winner selection and pointer advance, only when a grant is taken.
  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_o       = (req0_i && req1_i) ? ~last_q : req1_i;
    last_d      = last_q;
    if (en_i && gnt_valid_o) begin
      last_d = gnt_o;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter. One transaction at a time: the winner's
// command is latched in IDLE, executed in WR or RD, and acknowledged in RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  state_e        state_q, state_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic arb_en;
  logic gnt_valid;
  logic gnt;

  assign arb_en = (state_q == StIdle);

  mem_arbiter_rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_i      (bus.req0),
    .req1_i      (bus.req1),
    .en_i        (arb_en),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt)
  );

  // Next-state logic: grant/latch, write, read with timeout, response.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          port_d  = gnt;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (gnt) begin
            we_d    = bus.we1;
            addr_d  = bus.addr1;
            wdata_d = bus.wdata1;
            wmask_d = bus.wmask1;
          end else begin
            we_d    = bus.we0;
            addr_d  = bus.addr0;
            wdata_d = bus.wdata0;
            wmask_d = bus.wmask0;
          end
          state_d = we_d ? StWr : StRd;
        end
      end
      StWr: begin
        state_d = StResp;
      end
      StRd: begin
        if (bus.rd_valid) begin
          rdata_d = bus.rdata;
          state_d = StResp;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Last allowed RD cycle passed without data: abort with error.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state and the latched command only.
  always_comb begin
    bus.ren    = 1'b0;
    bus.wen    = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    bus.wmask  = MaskIdle;
    bus.ack0   = 1'b0;
    bus.rdata0 = '0;
    bus.err0   = 1'b0;
    bus.ack1   = 1'b0;
    bus.rdata1 = '0;
    bus.err1   = 1'b0;
    unique case (state_q)
      StWr: begin
        bus.wen   = 1'b1;
        bus.addr  = addr_q;
        bus.wdata = wdata_q;
        bus.wmask = wmask_q;
      end
      StRd: begin
        bus.ren  = 1'b1;
        bus.addr = addr_q;
      end
      StResp: begin
        if (port_q) begin
          bus.ack1   = 1'b1;
          bus.rdata1 = rdata_q;
          bus.err1   = err_q;
        end else begin
          bus.ack0   = 1'b1;
          bus.rdata0 = rdata_q;
          bus.err0   = err_q;
        end
      end
      default: begin
      end
    endcase
  end

  // State and latched-command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= MaskIdle;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, memory byte-address width.
REQ-002 Parameter W, default 32, data width.
REQ-003 Parameter TIMEOUT, default 15, max cycles waiting for rd_valid before abort.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 reqN  input  1  (N=0,1) request; held with command fields stable until ackN.
REQ-007 weN  input  1  1 = write, 0 = read.
REQ-008 addrN  input  AW  byte address.
REQ-009 wdataN  input  W  write data, already lane-aligned.
REQ-010 wmaskN  input  4  byte-lane write enables.
REQ-011 ackN  output  1  one-cycle completion pulse.
REQ-012 rdataN  output  W  read data, valid only while ackN=1 and command was a read.
REQ-013 errN  output  1  timeout flag, valid only while ackN=1.
REQ-014 ren  output  1  memory read enable.
REQ-015 wen  output  1  memory write enable.
REQ-016 addr  output  AW  memory address.
REQ-017 wdata  output  W  memory write data.
REQ-018 wmask  output  4  memory write mask.
REQ-019 rdata  input  W  memory read data, valid when rd_valid=1.
REQ-020 rd_valid  input  1  memory read-data valid, one or more cycles after ren asserted.

Function
REQ-021 FSM states: IDLE, WR, RD, RESP; no other reachable state.
REQ-022 IDLE: no req -> stay; any req -> latch winner's we/addr/wdata/wmask, go WR if we=1 else RD.
REQ-023 Arbitration round-robin: both requesting -> grant the port not granted last; single requester always wins; pointer updates only on a grant.
REQ-024 WR: wen=1 exactly one cycle with latched addr/wdata/wmask, then RESP.
REQ-025 RD: ren=1 and addr=latched address every cycle until rd_valid=1 or timeout; on rd_valid capture rdata, go RESP.
REQ-026 Timeout: cycle counter cleared on entry to RD; counter reaching TIMEOUT without rd_valid -> RESP with err=1, rdata=0.
REQ-027 RESP: ack of granted port =1 for exactly this cycle, with rdata/err; other port ack=0; next state IDLE unconditionally.
REQ-028 RESP exists so a req still high during ack is not re-granted; new arbitration starts earliest in following IDLE.
REQ-029 Latency: write req sampled at edge k -> wen cycle k+1 -> ack cycle k+2; read with rd_valid in first RD cycle -> ack cycle k+2.
REQ-030 Memory outputs derived from registered state and latched command only; no combinational path from reqN/addrN to memory port.
REQ-031 Outside WR/RD: ren=wen=0, addr=0, wdata=0, wmask=4'b1111; ren and wen never both 1.
REQ-032 rd_valid outside RD ignored; command field changes while granted ignored.
REQ-033 req dropped before ack: current transaction still completes and ack still pulses.

Reset
REQ-034 rst_n low -> immediately state=IDLE, RR pointer favors port 0, counter=0, all outputs 0 except wmask=4'b1111.
REQ-035 Reset mid-WR/RD aborts without ack; first grant after release follows REQ-023 from reset pointer.

Structure
REQ-036 State encodings and TIMEOUT default defined as constants in common.v.
REQ-037 Single sub-module rr_arb2 (two-input round-robin picker with pointer register); rest is flat FSM.

Verification
REQ-038 req0 write addr=16'h0100 wdata=32'hDEADBEEF wmask=4'b1111 -> wen one cycle with those values, ack0 two cycles after sample, err0=0.
REQ-039 req1 read addr=16'h0040, rd_valid after 3 cycles with rdata=32'h12345678 -> ren held 3 cycles, rdata1=32'h12345678 with ack1.
REQ-040 req0 and req1 asserted together, held -> grants alternate 0,1,0,1; no port acked twice consecutively.
REQ-041 Read with rd_valid never asserted -> ack pulse with err=1, rdata=0 after TIMEOUT=15 RD cycles; ren=0 afterwards.
REQ-042 rst_n pulled low during RD -> ren=0 immediately, no ack; next read after release completes normally.
REQ-043 Every cycle assert !(ren && wen) and at most one ackN high.
